// File: rtl/config_frame_sequencer_pkg.sv
// Shared constants for the configuration frame sequencer: header layout,
// opcodes, FSM states and error causes.
package config_frame_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_END   = 4'hF;

    // Header word field LSB positions
    localparam int OPC_LSB   = 28;
    localparam int COL_LSB   = 16;
    localparam int START_LSB = 8;
    localparam int CNT_LSB   = 0;

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_SRC_END  = 2'd0;
    localparam logic [1:0] ERR_OPCODE   = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

endpackage

// File: rtl/config_skid_buffer.sv
// One-entry 32-bit holding register. A push wins over a pop, so a
// simultaneous pop/push replaces the entry and leaves it full.
module config_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (push) begin
            dout <= din;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/config_frame_sequencer.sv
// Turns a stream of configuration words into column-select / frame-strobe
// writes: SETUP -> STROBE -> HOLD per data word, with a one-word skid buffer.
module config_frame_sequencer
    import config_frame_sequencer_pkg::*;
#(
    parameter int NUM_COLUMNS    = 16,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      word_valid,
    input  logic [31:0]               word_in,
    input  logic                      src_finished,
    output logic [NUM_COLUMNS-1:0]    col_select,
    output logic [FRAMES_PER_COL-1:0] frame_strobe,
    output logic [31:0]               frame_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code
);

    state_t      state, state_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  col_q, remaining;
    logic [4:0]  frame_idx;
    logic        skid_full, skid_push, skid_pop;
    logic [31:0] skid_q, cur_word;
    logic        cur_vld, hdr_ld, dat_ld, step, hdr_ok;
    logic [3:0]  opcode;

    config_skid_buffer u_skid (
        .clk  (clk),
        .reset(reset),
        .push (skid_push),
        .pop  (skid_pop),
        .din  (word_in),
        .dout (skid_q),
        .full (skid_full)
    );

    // A buffered word is always older than the incoming one, so it goes first
    assign cur_word = skid_full ? skid_q : word_in;
    assign cur_vld  = skid_full | word_valid;
    assign opcode   = cur_word[OPC_LSB +: 4];

    // 9-bit compares so start+count cannot wrap into range
    assign hdr_ok = ({1'b0, cur_word[COL_LSB +: 8]} < 9'(NUM_COLUMNS))
                 && (cur_word[CNT_LSB +: 8] != 8'd0)
                 && (({4'd0, cur_word[START_LSB +: 5]} + {1'b0, cur_word[CNT_LSB +: 8]})
                     <= 9'(FRAMES_PER_COL));

    always_comb begin
        state_d   = state;
        err_d     = err_q;
        hdr_ld    = 1'b0;
        dat_ld    = 1'b0;
        step      = 1'b0;
        skid_push = 1'b0;
        skid_pop  = 1'b0;
        case (state)
            S_HEADER: begin
                if (cur_vld) begin
                    skid_pop  = skid_full;
                    skid_push = skid_full & word_valid;
                    case (opcode)
                        OP_NOP: ;
                        OP_END: state_d = S_DONE;
                        OP_WRITE: begin
                            if (hdr_ok) begin
                                state_d = S_DATA_WAIT;
                                hdr_ld  = 1'b1;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = ERR_RANGE;
                            end
                        end
                        default: begin
                            state_d = S_ERROR;
                            err_d   = ERR_OPCODE;
                        end
                    endcase
                end else if (src_finished) begin
                    state_d = S_DONE;
                end
            end
            S_DATA_WAIT: begin
                if (src_finished) begin
                    state_d = S_ERROR;
                    err_d   = ERR_SRC_END;
                end else if (cur_vld) begin
                    skid_pop  = skid_full;
                    skid_push = skid_full & word_valid;
                    dat_ld    = 1'b1;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP, S_STROBE: begin
                state_d = (state == S_SETUP) ? S_STROBE : S_HOLD;
                if (state == S_STROBE && src_finished && remaining > 8'd1) begin
                    state_d = S_ERROR;
                    err_d   = ERR_SRC_END;
                end
                if (word_valid) begin
                    if (skid_full) begin
                        state_d = S_ERROR;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        skid_push = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                step = 1'b1;
                if (remaining == 8'd1) begin
                    state_d = S_HEADER;
                end else if (src_finished) begin
                    state_d = S_ERROR;
                    err_d   = ERR_SRC_END;
                end else if (skid_full) begin
                    state_d  = S_SETUP;
                    dat_ld   = 1'b1;
                    skid_pop = 1'b1;
                end else begin
                    state_d = S_DATA_WAIT;
                end
                // A word landing while the buffer drains simply refills it
                if (word_valid) begin
                    if (skid_full && !skid_pop) begin
                        state_d = S_ERROR;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        skid_push = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_HEADER;
            err_q      <= ERR_SRC_END;
            col_q      <= '0;
            frame_idx  <= '0;
            remaining  <= '0;
            frame_data <= '0;
            col_select <= '0;
        end else begin
            state <= state_d;
            err_q <= err_d;
            if (hdr_ld) begin
                col_q     <= cur_word[COL_LSB +: 8];
                frame_idx <= cur_word[START_LSB +: 5];
                remaining <= cur_word[CNT_LSB +: 8];
            end
            if (step) begin
                remaining <= remaining - 8'd1;
                frame_idx <= frame_idx + 5'd1;
            end
            if (dat_ld) begin
                frame_data <= cur_word;
                col_select <= NUM_COLUMNS'(1) << col_q;
            end
            if (state_d == S_HEADER || state_d == S_DONE || state_d == S_ERROR)
                col_select <= '0;
        end
    end

    assign frame_strobe = (state == S_STROBE) ? (FRAMES_PER_COL'(1) << frame_idx) : '0;
    assign busy     = (state == S_DATA_WAIT) || (state == S_SETUP)
                   || (state == S_STROBE)    || (state == S_HOLD);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign err_code = error ? err_q : ERR_SRC_END;

endmodule
